// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the LEGv8 core.
// Holds the PC, addresses a combinational instruction memory, and registers
// the fetched word together with its PC. Stall holds everything; flush and
// redirect squash the entering instruction into an all-zero bubble, and
// redirect also reloads the PC from the resolved branch target.
module fetch_stage #(
  parameter int                 ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              if_id_valid,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       fetch_count
);

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;
  logic              if_id_valid_reg;
  logic [ADDR_W-1:0] if_id_pc_reg;
  logic [31:0]       if_id_instr_reg;
  logic [31:0]       fetch_count_reg;
  logic              squash;
  logic              load;

  // Bubble when the entering fetch is on a wrong path; load only when nothing
  // asks IF/ID to hold or squash.
  assign squash = redirect | flush;
  assign load   = ~squash & ~stall;

  // Next-PC selection: redirect beats stall; the target is word-aligned by
  // dropping its two low bits. The increment wraps naturally at ADDR_W bits.
  always_comb begin
    pc_next = pc_reg + ADDR_W'(4);
    if (redirect) begin
      pc_next = {redirect_target[ADDR_W-1:2], 2'b00};
    end else if (stall) begin
      pc_next = pc_reg;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  // IF/ID register: bubble on squash, hold on stall, otherwise capture fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_valid_reg <= 1'b0;
      if_id_pc_reg    <= '0;
      if_id_instr_reg <= '0;
    end else if (squash) begin
      if_id_valid_reg <= 1'b0;
      if_id_pc_reg    <= '0;
      if_id_instr_reg <= '0;
    end else if (load) begin
      if_id_valid_reg <= 1'b1;
      if_id_pc_reg    <= pc_reg;
      if_id_instr_reg <= imem_rdata;
    end
  end

  // Count of valid instructions written into IF/ID; wraps at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_reg <= '0;
    end else if (load) begin
      fetch_count_reg <= fetch_count_reg + 32'd1;
    end
  end

  assign imem_addr   = pc_reg;
  assign if_id_valid = if_id_valid_reg;
  assign if_id_pc    = if_id_pc_reg;
  assign if_id_instr = if_id_instr_reg;
  assign fetch_count = fetch_count_reg;

endmodule
